// File: rtl/addr_step_pkg.sv
// Shared types for the stepping address register.
// Burst FSM states and limit-handling mode encodings.
package addr_step_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/addr_step_calc.sv
// Combinational next-value and wrap flag generation
// for bounded inc/dec and unbounded relative add.
module addr_step_calc
    import addr_step_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int STEP     = 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_limit,
    input  logic [WIDTH-1:0] i_offset,
    output logic [WIDTH-1:0] o_inc_val,
    output logic             o_inc_wrap,
    output logic [WIDTH-1:0] o_dec_val,
    output logic             o_dec_wrap,
    output logic [WIDTH-1:0] o_add_val,
    output logic             o_add_wrap
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH:0]   w_cur_x;
    logic [WIDTH:0]   w_lim_x;
    logic [WIDTH:0]   w_inc_sum;
    logic [WIDTH:0]   w_inc_wrapv;
    logic             w_inc_over;
    logic [WIDTH:0]   w_dec_diff;
    logic             w_dec_ok;
    logic [WIDTH-1:0] w_dec_wrapv;
    logic [WIDTH:0]   w_add_sum;

    assign w_cur_x     = {1'b0, i_cur};
    assign w_lim_x     = {1'b0, i_limit};
    assign w_inc_sum   = w_cur_x + STEP_X;
    assign w_inc_over  = w_inc_sum > w_lim_x;
    assign w_inc_wrapv = w_inc_sum - (w_lim_x + ONE_X);

    assign o_inc_wrap = w_inc_over;
    assign o_inc_val  = !w_inc_over ? w_inc_sum[WIDTH-1:0] :
                        (SATURATE == MODE_SAT) ? i_limit :
                        w_inc_wrapv[WIDTH-1:0];

    assign w_dec_diff  = w_cur_x - STEP_X;
    assign w_dec_ok    = (w_cur_x >= STEP_X) && (w_dec_diff <= w_lim_x);
    assign w_dec_wrapv = i_cur + i_limit + ONE - STEP_X[WIDTH-1:0];

    assign o_dec_wrap = !w_dec_ok;
    assign o_dec_val  = w_dec_ok ? w_dec_diff[WIDTH-1:0] :
                        (SATURATE == MODE_SAT) ? '0 :
                        w_dec_wrapv;

    // Negative offsets borrow exactly when the unsigned add has no carry.
    assign w_add_sum  = w_cur_x + {1'b0, i_offset};
    assign o_add_val  = w_add_sum[WIDTH-1:0];
    assign o_add_wrap = i_offset[WIDTH-1] ? !w_add_sum[WIDTH] :
                        w_add_sum[WIDTH];

endmodule

// File: rtl/addr_step_reg.sv
// Address/counter register with load, bounded step, relative
// add and an autonomous N-step burst mode.
module addr_step_reg
    import addr_step_pkg::*;
#(
    parameter int                 WIDTH     = 16,
    parameter int                 STEP      = 1,
    parameter int                 LEN_W     = 8,
    parameter int                 SATURATE  = MODE_WRAP,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_en,
    input  logic [WIDTH-1:0] datain,
    input  logic             inc,
    input  logic             dec,
    input  logic             add_en,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] limit,
    input  logic             burst_start,
    input  logic [LEN_W-1:0] burst_len,
    output logic [WIDTH-1:0] dataout,
    output logic             at_limit,
    output logic             wrapped,
    output logic             busy,
    output logic             done,
    output logic             conflict
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_wrapped;
    logic             w_wrapped_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_conflict;
    logic             w_conflict_nxt;

    logic [WIDTH-1:0] w_inc_val;
    logic             w_inc_wrap;
    logic [WIDTH-1:0] w_dec_val;
    logic             w_dec_wrap;
    logic [WIDTH-1:0] w_add_val;
    logic             w_add_wrap;
    logic             w_ctl_any;

    addr_step_calc #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_calc (
        .i_cur      (r_data),
        .i_limit    (limit),
        .i_offset   (offset),
        .o_inc_val  (w_inc_val),
        .o_inc_wrap (w_inc_wrap),
        .o_dec_val  (w_dec_val),
        .o_dec_wrap (w_dec_wrap),
        .o_add_val  (w_add_val),
        .o_add_wrap (w_add_wrap)
    );

    assign w_ctl_any = inc | dec | add_en | burst_start;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_data_nxt     = r_data;
        w_wrapped_nxt  = r_wrapped;
        w_done_nxt     = 1'b0;
        w_conflict_nxt = 1'b0;
        if (write_en) begin
            w_data_nxt     = datain;
            w_wrapped_nxt  = 1'b0;
            w_state_nxt    = IDLE;
            w_conflict_nxt = w_ctl_any;
        end else if (r_state == BURST) begin
            w_data_nxt     = w_inc_val;
            w_wrapped_nxt  = r_wrapped | w_inc_wrap;
            w_cnt_nxt      = r_cnt - LEN_W'(1);
            w_conflict_nxt = w_ctl_any;
            if (r_cnt == LEN_W'(1)) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
        end else if (burst_start) begin
            // Starting a burst takes the cycle; other controls are dropped.
            w_cnt_nxt      = burst_len;
            w_conflict_nxt = inc | dec | add_en;
            if (burst_len == '0) begin
                w_done_nxt = 1'b1;
            end else begin
                w_state_nxt = BURST;
            end
        end else if (add_en) begin
            w_data_nxt     = w_add_val;
            w_wrapped_nxt  = r_wrapped | w_add_wrap;
            w_conflict_nxt = inc | dec;
        end else if (inc && dec) begin
            w_conflict_nxt = 1'b1;
        end else if (inc) begin
            w_data_nxt    = w_inc_val;
            w_wrapped_nxt = r_wrapped | w_inc_wrap;
        end else if (dec) begin
            w_data_nxt    = w_dec_val;
            w_wrapped_nxt = r_wrapped | w_dec_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_data     <= RESET_VAL;
            r_wrapped  <= 1'b0;
            r_done     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data     <= w_data_nxt;
            r_wrapped  <= w_wrapped_nxt;
            r_done     <= w_done_nxt;
            r_conflict <= w_conflict_nxt;
        end
    end

    assign dataout  = r_data;
    assign at_limit = (r_data == limit);
    assign wrapped  = r_wrapped;
    assign busy     = (r_state == BURST);
    assign done     = r_done;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_addr_step_reg.sv
// Scoreboard bench: three register variants share one stimulus
// stream; each vector names the variant whose outputs it checks.
module tb_addr_step_reg;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] data;
        logic [4:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write_en = 1'b0;
    logic [15:0] datain = '0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        add_en = 1'b0;
    logic [15:0] offset = '0;
    logic [15:0] limit = 16'hFFFF;
    logic        burst_start = 1'b0;
    logic [7:0]  burst_len = '0;

    logic [15:0] data_v [3];
    logic [2:0]  atl_v;
    logic [2:0]  wr_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  conf_v;

    logic        s_rst, s_we, s_inc, s_dec, s_add, s_bs;
    logic [15:0] s_din, s_off, s_lim;
    logic [7:0]  s_blen;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   drained = 1'b0;

    always #5 clk = ~clk;

    addr_step_reg #(.STEP(1), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .write_en(write_en), .datain(datain),
        .inc(inc), .dec(dec), .add_en(add_en), .offset(offset),
        .limit(limit), .burst_start(burst_start), .burst_len(burst_len),
        .dataout(data_v[0]), .at_limit(atl_v[0]), .wrapped(wr_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .conflict(conf_v[0])
    );

    addr_step_reg #(.STEP(1), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .write_en(write_en), .datain(datain),
        .inc(inc), .dec(dec), .add_en(add_en), .offset(offset),
        .limit(limit), .burst_start(burst_start), .burst_len(burst_len),
        .dataout(data_v[1]), .at_limit(atl_v[1]), .wrapped(wr_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .conflict(conf_v[1])
    );

    addr_step_reg #(.STEP(2), .SATURATE(0)) u_step2 (
        .clk(clk), .rst(rst), .write_en(write_en), .datain(datain),
        .inc(inc), .dec(dec), .add_en(add_en), .offset(offset),
        .limit(limit), .burst_start(burst_start), .burst_len(burst_len),
        .dataout(data_v[2]), .at_limit(atl_v[2]), .wrapped(wr_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .conflict(conf_v[2])
    );

    task automatic clr();
        s_rst = 0; s_we = 0; s_inc = 0; s_dec = 0;
        s_add = 0; s_bs = 0; s_din = '0; s_off = '0;
        s_blen = '0;
    endtask

    // flags = {wrapped, busy, done, conflict, at_limit}
    task automatic step(input string nm, input int sel,
                        input logic [15:0] ed, input logic [4:0] ef);
        exp_t e;
        @(negedge clk);
        rst = s_rst; write_en = s_we; datain = s_din;
        inc = s_inc; dec = s_dec; add_en = s_add;
        offset = s_off; limit = s_lim;
        burst_start = s_bs; burst_len = s_blen;
        e.name = nm; e.sel = sel; e.data = ed; e.flags = ef;
        q.push_back(e);
        clr();
    endtask

    initial begin : monitor
        exp_t e;
        logic [15:0] ad;
        logic [4:0]  af;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                ad = data_v[e.sel];
                af = {wr_v[e.sel], busy_v[e.sel], done_v[e.sel],
                      conf_v[e.sel], atl_v[e.sel]};
                n_vec++;
                if (ad !== e.data || af !== e.flags) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h flags=%b, want data=%h flags=%b",
                             e.name, ad, af, e.data, e.flags);
                end
            end
        end
    end

    initial begin : driver
        clr();
        s_lim = 16'hFFFF;
        s_rst = 1; step("reset", 0, 16'h0000, 5'b00000);
        s_we = 1; s_din = 16'h1234; step("load", 0, 16'h1234, 5'b00000);

        s_lim = 16'd9;
        s_we = 1; s_din = 16'd8; step("wload8", 0, 16'd8, 5'b00000);
        s_inc = 1; step("winc9", 0, 16'd9, 5'b00001);
        s_inc = 1; step("wincwrap", 0, 16'd0, 5'b10000);
        s_inc = 1; step("winc1", 0, 16'd1, 5'b10000);

        s_we = 1; s_din = 16'd9; step("sload9", 1, 16'd9, 5'b00001);
        s_inc = 1; step("sincclamp", 1, 16'd9, 5'b10001);
        s_we = 1; s_din = 16'd0; step("sload0", 1, 16'd0, 5'b00000);
        s_dec = 1; step("sdecclamp", 1, 16'd0, 5'b10000);

        s_lim = 16'hFFFF;
        s_we = 1; s_din = 16'h0100; step("bload", 2, 16'h0100, 5'b00000);
        s_bs = 1; s_blen = 8'd4; s_inc = 1;
        step("bstart", 2, 16'h0100, 5'b01010);
        s_inc = 1; step("bstep1", 2, 16'h0102, 5'b01010);
        s_inc = 1; step("bstep2", 2, 16'h0104, 5'b01010);
        s_inc = 1; step("bstep3", 2, 16'h0106, 5'b01010);
        s_inc = 1; step("bstep4", 2, 16'h0108, 5'b00110);
        step("bidle", 2, 16'h0108, 5'b00000);

        s_we = 1; s_inc = 1; s_din = 16'h00AA;
        step("we_inc", 0, 16'h00AA, 5'b00010);
        s_inc = 1; s_dec = 1; step("inc_dec", 0, 16'h00AA, 5'b00010);
        s_we = 1; step("load0", 0, 16'h0000, 5'b00000);
        s_add = 1; s_off = 16'hFFFF; step("add_neg", 0, 16'hFFFF, 5'b10001);
        s_add = 1; s_inc = 1; s_off = 16'h0002;
        step("add_inc", 0, 16'h0001, 5'b10010);

        s_we = 1; s_din = 16'h0200; step("aload", 2, 16'h0200, 5'b00000);
        s_bs = 1; s_blen = 8'd5; step("astart", 2, 16'h0200, 5'b01000);
        step("astep1", 2, 16'h0202, 5'b01000);
        s_we = 1; s_din = 16'h0050; step("abort", 2, 16'h0050, 5'b00000);
        step("abort_nodone", 2, 16'h0050, 5'b00000);

        s_bs = 1; s_blen = 8'd3; step("rstart", 2, 16'h0050, 5'b01000);
        step("rstep1", 2, 16'h0052, 5'b01000);
        s_rst = 1; step("rabort", 2, 16'h0000, 5'b00000);
        step("rabort_nodone", 2, 16'h0000, 5'b00000);

        s_bs = 1; s_blen = 8'd0; step("zlen", 2, 16'h0000, 5'b00100);
        step("zlen_after", 2, 16'h0000, 5'b00000);

        for (int i = 0; i < 20 && !drained; i++) begin
            @(negedge clk);
            if (q.size() == 0) drained = 1'b1;
        end
        if (!drained) begin
            n_fail++;
            $display("FAIL drain: %0d left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
